alu_sequencer: RTL and testbench

Multi-cycle control sequencer for the shared 32-bit ALU and its Y/Z register pair. It accepts one operation request at a time from instruction control. It then walks the datapath through operand load, execute and write-back phases by driving one-hot bus strobes and the ALU opcode. Multiply and divide results are 64 bits and are written back to LO/HI. All other results are written back to the destination register.

---
 rtl/alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer for the shared 32-bit ALU and
// its Y/Z register pair. It accepts one request at a time and walks the
// datapath through LOAD_Y -> EXEC -> WB_LO (-> WB_HI for mul/div).
//
// Ports:
//   clock, clear (async active-low reset)
//   start, opcode[4:0]             request from instruction control
//   busy, done, illegal            status (registered)
//   alu_op[4:0]                    ALU opcode, latched opcode during EXEC only
//   ra_out, rb_out, c_out          operand bus drivers
//   y_in, z_in                     Y / Z load strobes
//   zlo_out, zhi_out               Z halves onto the bus
//   rz_in, lo_in, hi_in            write-back destinations
module alu_sequencer #(
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [4:0] alu_op,
  output logic       ra_out,
  output logic       rb_out,
  output logic       c_out,
  output logic       y_in,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       rz_in,
  output logic       lo_in,
  output logic       hi_in
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Y = 3'd1,
    EXEC   = 3'd2,
    WB_LO  = 3'd3,
    WB_HI  = 3'd4
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_cnt;

  // Legal opcodes form the contiguous range add (3) .. not (18).
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op >= OP_W'(3)) && (op <= OP_W'(18));
  endfunction

  function automatic logic is_long(input logic [OP_W-1:0] op);
    return (op == OP_W'(15)) || (op == OP_W'(16));
  endfunction

  function automatic logic is_imm(input logic [OP_W-1:0] op);
    return (op >= OP_W'(12)) && (op <= OP_W'(14));
  endfunction

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_W'(17)) || (op == OP_W'(18));
  endfunction

  // Decoded classes of the latched opcode; outputs never depend on start/opcode.
  logic w_long;
  logic w_imm;
  logic w_opb_rb;

  assign w_long   = is_long(r_op);
  assign w_imm    = is_imm(r_op);
  assign w_opb_rb = !is_imm(r_op) && !is_unary(r_op);

  // Sequencer: every output is registered with the value for the next state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      alu_op  <= '0;
      ra_out  <= 1'b0;
      rb_out  <= 1'b0;
      c_out   <= 1'b0;
      y_in    <= 1'b0;
      z_in    <= 1'b0;
      zlo_out <= 1'b0;
      zhi_out <= 1'b0;
      rz_in   <= 1'b0;
      lo_in   <= 1'b0;
      hi_in   <= 1'b0;
    end else begin
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      alu_op  <= '0;
      ra_out  <= 1'b0;
      rb_out  <= 1'b0;
      c_out   <= 1'b0;
      y_in    <= 1'b0;
      z_in    <= 1'b0;
      zlo_out <= 1'b0;
      zhi_out <= 1'b0;
      rz_in   <= 1'b0;
      lo_in   <= 1'b0;
      hi_in   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            if (is_legal(opcode)) begin
              r_op    <= opcode;
              r_state <= LOAD_Y;
              busy    <= 1'b1;
              ra_out  <= 1'b1;
              y_in    <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end

        LOAD_Y: begin
          r_state <= EXEC;
          busy    <= 1'b1;
          alu_op  <= r_op;
          rb_out  <= w_opb_rb;
          c_out   <= w_imm;
          // Remaining extra EXEC cycles after the first one.
          r_cnt   <= w_long ? CNT_W'(MULDIV_WAIT) : '0;
          z_in    <= !w_long || (MULDIV_WAIT == 0);
        end

        EXEC: begin
          busy <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= WB_LO;
            zlo_out <= 1'b1;
            rz_in   <= !w_long;
            lo_in   <= w_long;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            alu_op <= r_op;
            rb_out <= w_opb_rb;
            c_out  <= w_imm;
            z_in   <= (r_cnt == CNT_W'(1));
          end
        end

        WB_LO: begin
          if (w_long) begin
            r_state <= WB_HI;
            busy    <= 1'b1;
            zhi_out <= 1'b1;
            hi_in   <= 1'b1;
          end else begin
            r_state <= IDLE;
            done    <= 1'b1;
          end
        end

        WB_HI: begin
          r_state <= IDLE;
          done    <= 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: one instance with MULDIV_WAIT=2 and
// one with MULDIV_WAIT=0, expected strobe patterns written out per cycle.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic       start, start0;
  logic [4:0] opcode, opcode0;

  logic       busy, done, illegal, ra_out, rb_out, c_out, y_in, z_in;
  logic       zlo_out, zhi_out, rz_in, lo_in, hi_in;
  logic [4:0] alu_op;
  logic       busy0, done0, illegal0, ra_out0, rb_out0, c_out0, y_in0, z_in0;
  logic       zlo_out0, zhi_out0, rz_in0, lo_in0, hi_in0;
  logic [4:0] alu_op0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_sequencer #(.MULDIV_WAIT(2)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal), .alu_op(alu_op),
    .ra_out(ra_out), .rb_out(rb_out), .c_out(c_out), .y_in(y_in), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .rz_in(rz_in), .lo_in(lo_in),
    .hi_in(hi_in)
  );

  alu_sequencer #(.MULDIV_WAIT(0)) dut0 (
    .clock(clock), .clear(clear), .start(start0), .opcode(opcode0),
    .busy(busy0), .done(done0), .illegal(illegal0), .alu_op(alu_op0),
    .ra_out(ra_out0), .rb_out(rb_out0), .c_out(c_out0), .y_in(y_in0),
    .z_in(z_in0), .zlo_out(zlo_out0), .zhi_out(zhi_out0), .rz_in(rz_in0),
    .lo_in(lo_in0), .hi_in(hi_in0)
  );

  // Strobe bit positions within the packed observation vector.
  localparam logic [12:0] BUSY = 13'h1000;
  localparam logic [12:0] DONE = 13'h0800;
  localparam logic [12:0] ILL  = 13'h0400;
  localparam logic [12:0] RA   = 13'h0200;
  localparam logic [12:0] RB   = 13'h0100;
  localparam logic [12:0] C    = 13'h0080;
  localparam logic [12:0] Y    = 13'h0040;
  localparam logic [12:0] Z    = 13'h0020;
  localparam logic [12:0] ZLO  = 13'h0010;
  localparam logic [12:0] ZHI  = 13'h0008;
  localparam logic [12:0] RZ   = 13'h0004;
  localparam logic [12:0] LO   = 13'h0002;
  localparam logic [12:0] HI   = 13'h0001;

  logic [12:0] obs, obs0;
  assign obs  = {busy, done, illegal, ra_out, rb_out, c_out, y_in, z_in,
                 zlo_out, zhi_out, rz_in, lo_in, hi_in};
  assign obs0 = {busy0, done0, illegal0, ra_out0, rb_out0, c_out0, y_in0, z_in0,
                 zlo_out0, zhi_out0, rz_in0, lo_in0, hi_in0};

  task automatic chk(input string tag, input logic [12:0] o, input logic [4:0] oa,
                     input logic [12:0] e, input logic [4:0] ea);
    checks++;
    assert ({o, oa} === {e, ea}) else begin
      failures++;
      $error("FAIL %s observed strobes=%h alu_op=%0d expected strobes=%h alu_op=%0d",
             tag, o, oa, e, ea);
    end
  endtask

  // At most one bus driver per cycle on either instance.
  always @(negedge clock) begin
    checks++;
    assert (($countones({ra_out, rb_out, c_out, zlo_out, zhi_out}) <= 1) &&
            ($countones({ra_out0, rb_out0, c_out0, zlo_out0, zhi_out0}) <= 1))
    else begin
      failures++;
      $error("FAIL bus_drivers observed=%b/%b expected at most one high",
             {ra_out, rb_out, c_out, zlo_out, zhi_out},
             {ra_out0, rb_out0, c_out0, zlo_out0, zhi_out0});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; opcode = 5'd0; start0 = 1'b0; opcode0 = 5'd0;
    step(); step();
    chk("reset", obs, alu_op, 13'h0, 5'd0);
    chk("reset0", obs0, alu_op0, 13'h0, 5'd0);
    clear = 1'b1;
    step();

    // add, then sub back-to-back in the done cycle, with a start ignored in EXEC
    start = 1'b1; opcode = 5'd3;
    step(); start = 1'b0;
    chk("add_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); chk("add_c2", obs, alu_op, BUSY | RB | Z, 5'd3);
    step(); chk("add_c3", obs, alu_op, BUSY | ZLO | RZ, 5'd0);
    step(); chk("add_c4", obs, alu_op, DONE, 5'd0);
    start = 1'b1; opcode = 5'd4;
    step(); start = 1'b0;
    chk("sub_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); chk("sub_c2", obs, alu_op, BUSY | RB | Z, 5'd4);
    start = 1'b1; opcode = 5'd5;
    step(); start = 1'b0;
    chk("sub_c3", obs, alu_op, BUSY | ZLO | RZ, 5'd0);
    step(); chk("sub_c4", obs, alu_op, DONE, 5'd0);
    step(); chk("ignored_start", obs, alu_op, 13'h0, 5'd0);

    // mul on both instances: MULDIV_WAIT=2 and MULDIV_WAIT=0
    start = 1'b1; opcode = 5'd16; start0 = 1'b1; opcode0 = 5'd16;
    step(); start = 1'b0; start0 = 1'b0;
    chk("mul_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    chk("mul0_c1", obs0, alu_op0, BUSY | RA | Y, 5'd0);
    step();
    chk("mul_c2", obs, alu_op, BUSY | RB, 5'd16);
    chk("mul0_c2", obs0, alu_op0, BUSY | RB | Z, 5'd16);
    step();
    chk("mul_c3", obs, alu_op, BUSY | RB, 5'd16);
    chk("mul0_c3", obs0, alu_op0, BUSY | ZLO | LO, 5'd0);
    step();
    chk("mul_c4", obs, alu_op, BUSY | RB | Z, 5'd16);
    chk("mul0_c4", obs0, alu_op0, BUSY | ZHI | HI, 5'd0);
    step();
    chk("mul_c5", obs, alu_op, BUSY | ZLO | LO, 5'd0);
    chk("mul0_c5", obs0, alu_op0, DONE, 5'd0);
    step();
    chk("mul_c6", obs, alu_op, BUSY | ZHI | HI, 5'd0);
    chk("mul0_c6", obs0, alu_op0, 13'h0, 5'd0);
    step(); chk("mul_c7", obs, alu_op, DONE, 5'd0);
    step(); chk("mul_c8", obs, alu_op, 13'h0, 5'd0);

    // andi: immediate operand via c_out
    start = 1'b1; opcode = 5'd13;
    step(); start = 1'b0;
    chk("andi_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); chk("andi_c2", obs, alu_op, BUSY | C | Z, 5'd13);
    step(); chk("andi_c3", obs, alu_op, BUSY | ZLO | RZ, 5'd0);
    step(); chk("andi_c4", obs, alu_op, DONE, 5'd0);

    // not: unary, no operand-B driver
    start = 1'b1; opcode = 5'd18;
    step(); start = 1'b0;
    chk("not_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); chk("not_c2", obs, alu_op, BUSY | Z, 5'd18);
    step(); chk("not_c3", obs, alu_op, BUSY | ZLO | RZ, 5'd0);
    step(); chk("not_c4", obs, alu_op, DONE, 5'd0);

    // illegal 00000 then 11111, then div accepted the next cycle
    start = 1'b1; opcode = 5'd0;
    step(); chk("ill_00000", obs, alu_op, ILL, 5'd0);
    opcode = 5'd31;
    step(); chk("ill_11111", obs, alu_op, ILL, 5'd0);
    opcode = 5'd15;
    step(); start = 1'b0;
    chk("div_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); chk("div_c2", obs, alu_op, BUSY | RB, 5'd15);
    step(); step();
    chk("div_c4", obs, alu_op, BUSY | RB | Z, 5'd15);
    step(); chk("div_c5", obs, alu_op, BUSY | ZLO | LO, 5'd0);
    step(); chk("div_c6", obs, alu_op, BUSY | ZHI | HI, 5'd0);
    step(); chk("div_c7", obs, alu_op, DONE, 5'd0);

    // reset asserted mid-EXEC of a mul
    start = 1'b1; opcode = 5'd16;
    step(); start = 1'b0;
    step();
    chk("rst_pre", obs, alu_op, BUSY | RB, 5'd16);
    #2 clear = 1'b0;
    #1 chk("rst_async", obs, alu_op, 13'h0, 5'd0);
    step();
    clear = 1'b1;
    step(); step(); step();
    chk("rst_no_done", obs, alu_op, 13'h0, 5'd0);
    start = 1'b1; opcode = 5'd3;
    step(); start = 1'b0;
    chk("post_rst_c1", obs, alu_op, BUSY | RA | Y, 5'd0);
    step(); step(); step();
    chk("post_rst_c4", obs, alu_op, DONE, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
